dmem_loader: RTL

- Host-side debug loader for the data memory. It is the driver end of the backend's debug_dmem_oe/we/addr/data port.
- It takes a byte-stream command protocol from a serial receiver and holds the CPU core in reset via cpu_hold. While the core is held, it writes host words into the SRAM or reads them back onto a transmit byte stream.
- A GO command releases the core. The loader then idles until the next reset.

---
 rtl/dbg_pkg.sv | 26 ++
 rtl/byte_packer.sv | 39 +++
 rtl/dmem_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug data-memory loader: protocol opcodes,
// the loader state encoding and the fixed header length.
package dbg_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_GO     = 8'h47;
    localparam logic [7:0] RSP_ACK   = 8'h4B;

    // Header is addr[31:0] followed by len[15:0], both little-endian
    localparam int HDR_BYTES = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD,
        ST_RPULSE,
        ST_RSEND,
        ST_ACK,
        ST_RUN
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Four-byte little-endian word buffer. Received bytes shift in from the top
// so the first byte ends up in bits [7:0]; read words load in parallel and
// shift out from the bottom, LSB first. A 2-bit counter tracks the byte lane.
module byte_packer
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_in,
    input  logic        shift_out,
    input  logic        load,
    input  logic [7:0]  in_byte,
    input  logic [31:0] load_word,
    output logic [31:0] word,
    output logic [1:0]  count
);

    // Word register and byte-lane counter; load wins over every other request
    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= 32'h0;
            count <= 2'd0;
        end else if (load) begin
            word  <= load_word;
            count <= 2'd0;
        end else if (clear) begin
            word  <= 32'h0;
            count <= 2'd0;
        end else if (shift_in) begin
            word  <= {in_byte, word[31:8]};
            count <= count + 2'd1;
        end else if (shift_out) begin
            word  <= {8'h00, word[31:8]};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Host-side debug loader for the data memory. Decodes a byte-stream command
// protocol, writes or reads SRAM words through the debug_dmem_* port while the
// core is held in reset, and releases the core on a GO command.
module dmem_loader
    import dbg_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int WE_CYCLES = 1,
    parameter int RD_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cpu_hold,
    output logic        debug_dmem_oe,
    output logic        debug_dmem_we,
    output logic [31:0] debug_dmem_addr,
    output logic [31:0] debug_dmem_data,
    input  logic [31:0] dmem_rdata,
    output logic        err
);

    localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);
    localparam logic [3:0] WE_LAST  = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RD_LAST  = 4'(RD_CYCLES - 1);

    state_t              state;
    logic [2:0]          hdr_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [15:0]         len;
    logic [3:0]          pulse_cnt;
    logic                is_write;

    logic                rx_fire;
    logic                tx_fire;
    logic [31:0]         addr_ins;
    logic [15:0]         len_ins;
    logic [15:0]         len_dec;
    logic [ADDR_W-1:0]   addr_inc;

    logic                pk_clear;
    logic                pk_shift_in;
    logic                pk_shift_out;
    logic                pk_load;
    logic [31:0]         pk_word;
    logic [1:0]          pk_count;

    assign rx_fire  = rx_valid & rx_ready;
    assign tx_fire  = tx_valid & tx_ready;
    assign len_dec  = len - 16'd1;
    assign addr_inc = addr + ADDR_W'(1);

    // Only the low ADDR_W address bits are kept, so the upper header bits drop out
    assign debug_dmem_addr = 32'(addr);
    assign debug_dmem_data = pk_word;

    // Packer control: start a fresh word after the header, shift RX bytes in,
    // load the SRAM word on the last oe cycle, shift TX bytes out as they go
    assign pk_clear     = (state == ST_HDR) && rx_fire && (hdr_cnt == HDR_LAST);
    assign pk_shift_in  = (state == ST_WDATA) && rx_fire;
    assign pk_load      = (state == ST_RPULSE) && (pulse_cnt == RD_LAST);
    assign pk_shift_out = (state == ST_RSEND) && tx_fire && (pk_count != 2'd3);

    // Drop the current header byte into its little-endian slot of addr or len
    always_comb begin
        addr_ins = 32'(addr);
        len_ins  = len;
        case (hdr_cnt)
            3'd0:    addr_ins[7:0]   = rx_data;
            3'd1:    addr_ins[15:8]  = rx_data;
            3'd2:    addr_ins[23:16] = rx_data;
            3'd3:    addr_ins[31:24] = rx_data;
            3'd4:    len_ins[7:0]    = rx_data;
            3'd5:    len_ins[15:8]   = rx_data;
            default: ;
        endcase
    end

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .shift_in  (pk_shift_in),
        .shift_out (pk_shift_out),
        .load      (pk_load),
        .in_byte   (rx_data),
        .load_word (dmem_rdata),
        .word      (pk_word),
        .count     (pk_count)
    );

    // Command FSM; every output is registered and set on the transition into its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            hdr_cnt       <= 3'd0;
            addr          <= '0;
            len           <= 16'd0;
            pulse_cnt     <= 4'd0;
            is_write      <= 1'b0;
            cpu_hold      <= 1'b1;
            rx_ready      <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            debug_dmem_oe <= 1'b0;
            debug_dmem_we <= 1'b0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        case (rx_data)
                            OP_WRITE: begin
                                is_write <= 1'b1;
                                hdr_cnt  <= 3'd0;
                                state    <= ST_HDR;
                            end
                            OP_READ: begin
                                is_write <= 1'b0;
                                hdr_cnt  <= 3'd0;
                                state    <= ST_HDR;
                            end
                            OP_GO: begin
                                cpu_hold <= 1'b0;
                                rx_ready <= 1'b0;
                                state    <= ST_RUN;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end

                ST_HDR: begin
                    if (rx_fire) begin
                        addr    <= addr_ins[ADDR_W-1:0];
                        len     <= len_ins;
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == HDR_LAST) begin
                            if (is_write) begin
                                if (len_ins == 16'd0) begin
                                    rx_ready <= 1'b0;
                                    tx_valid <= 1'b1;
                                    tx_data  <= RSP_ACK;
                                    state    <= ST_ACK;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end else begin
                                if (len_ins == 16'd0) begin
                                    state <= ST_IDLE;
                                end else begin
                                    rx_ready      <= 1'b0;
                                    debug_dmem_oe <= 1'b1;
                                    pulse_cnt     <= 4'd0;
                                    state         <= ST_RPULSE;
                                end
                            end
                        end
                    end
                end

                ST_WDATA: begin
                    if (rx_fire && (pk_count == 2'd3)) begin
                        rx_ready <= 1'b0;
                        state    <= ST_WSETUP;
                    end
                end

                ST_WSETUP: begin
                    debug_dmem_we <= 1'b1;
                    pulse_cnt     <= 4'd0;
                    state         <= ST_WPULSE;
                end

                ST_WPULSE: begin
                    if (pulse_cnt == WE_LAST) begin
                        debug_dmem_we <= 1'b0;
                        state         <= ST_WHOLD;
                    end else begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end
                end

                ST_WHOLD: begin
                    addr <= addr_inc;
                    len  <= len_dec;
                    if (len_dec != 16'd0) begin
                        rx_ready <= 1'b1;
                        state    <= ST_WDATA;
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_ACK;
                        state    <= ST_ACK;
                    end
                end

                ST_RPULSE: begin
                    if (pulse_cnt == RD_LAST) begin
                        debug_dmem_oe <= 1'b0;
                        tx_valid      <= 1'b1;
                        tx_data       <= dmem_rdata[7:0];
                        state         <= ST_RSEND;
                    end else begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end
                end

                ST_RSEND: begin
                    if (tx_fire) begin
                        if (pk_count == 2'd3) begin
                            tx_valid <= 1'b0;
                            addr     <= addr_inc;
                            len      <= len_dec;
                            if (len_dec != 16'd0) begin
                                debug_dmem_oe <= 1'b1;
                                pulse_cnt     <= 4'd0;
                                state         <= ST_RPULSE;
                            end else begin
                                rx_ready <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            tx_data <= pk_word[15:8];
                        end
                    end
                end

                ST_ACK: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    cpu_hold      <= 1'b0;
                    rx_ready      <= 1'b0;
                    debug_dmem_oe <= 1'b0;
                    debug_dmem_we <= 1'b0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
